frame_ram_arbiter: RTL
======================

FRAME_RAM_ARBITER -- requirements
Module: frame_ram_arbiter

Interface
REQ-001 Parameter ADDR_W, 16, frame RAM word-address width; bit ADDR_W-1 is the frame bank bit.
REQ-002 Parameter DATA_W, 16, frame RAM data width.
REQ-003 Sys_clk  in  1  single clock; all logic rises on this edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 frame_end  in  1  one-cycle pulse, end of captured video frame.
REQ-006 vw_req  in  1  video write request, held until vw_ack.
REQ-007 vw_addr  in  ADDR_W-1  video pixel address within bank.
REQ-008 vw_data  in  DATA_W  video pixel data.
REQ-009 vw_ack  out  1  video write accepted.
REQ-010 fd_req  in  1  detection read request, held until fd_ack.
REQ-011 fd_addr  in  ADDR_W-1  detection read address within bank.
REQ-012 fd_ack  out  1  detection read accepted.
REQ-013 fd_rdata  out  DATA_W  detection read data.
REQ-014 fd_valid  out  1  fd_rdata valid pulse.
REQ-015 host_req  in  1  host read request, held until host_ack.
REQ-016 host_addr  in  ADDR_W  host full read address.
REQ-017 host_ack  out  1  host read accepted.
REQ-018 host_rdata  out  DATA_W  host read data.
REQ-019 host_valid  out  1  host_rdata valid pulse.
REQ-020 host_waitx  out  1  active-low host bus wait.
REQ-021 ram_addr  out  ADDR_W  RAM address.
REQ-022 ram_wdata  out  DATA_W  RAM write data.
REQ-023 ram_wren  out  1  RAM write enable.
REQ-024 ram_rden  out  1  RAM read enable.
REQ-025 ram_q  in  DATA_W  RAM read data, valid one cycle after ram_rden.
REQ-026 wr_bank  out  1  bank currently written by video.

Function
REQ-027 FSM states IDLE, WRITE, READ, RDATA; exactly one access in flight.
REQ-028 IDLE grant priority: vw_req first, then readers per REQ-036; none pending stays IDLE.
REQ-029 Address/data latched at grant; requester input changes afterward are ignored.
REQ-030 Write: IDLE at N -> WRITE at N+1 (ram_wren=1, vw_ack=1, ram_addr={wr_bank,vw_addr}) -> IDLE at N+2.
REQ-031 Read: IDLE at N -> READ at N+1 (ram_rden=1) -> RDATA at N+2 (ack=1) -> IDLE at N+3; rdata registered from ram_q at end of RDATA, valid pulses at N+3.
REQ-032 Detection read address = {~wr_bank, fd_addr}; host read uses host_addr unmodified.
REQ-033 ram_wren and ram_rden never both 1; both 0 outside WRITE/READ; ram_addr holds last value when idle.
REQ-034 wr_bank toggles on frame_end; in-flight access keeps its latched address; frame_end coincident with an IDLE write grant: grant uses pre-toggle bank.
REQ-035 Requester drops req the cycle after its ack; IDLE re-samples, so back-to-back requests are legal with no idle gap beyond REQ-030/031.
REQ-036 Reader selection per Configuration; vw_req arriving during a read waits at most 2 cycles.
REQ-037 host_waitx=0 while host_req=1 and no host_valid since host_req rose; returns 1 in host_valid cycle; 1 while host_req=0.
REQ-038 fd_rdata/host_rdata hold until that requester's next valid.

Reset
REQ-039 reset forces IDLE, wr_bank=0, all acks/valids/ram_wren/ram_rden=0, host_waitx=1, rdata=0, round-robin pointer to detection-first, in the same edge.
REQ-040 reset during WRITE or READ abandons the access; no ack or valid issued for it.

Configuration
REQ-041 Macro FRAME_RAM_RR_FAIRNESS_EN defined: readers round-robin; pointer flips to the other reader after each read grant.
REQ-042 Macro absent: fixed priority, detection before host; no pointer state.

Verification
REQ-043 Single vw_req, vw_addr=0x0010, vw_data=0xF800, wr_bank=0 -> ram_wren one cycle at N+1, ram_addr=0x0010, vw_ack same cycle.
REQ-044 fd_req fd_addr=0x0005, wr_bank=0, ram_q=0x1234 -> ram_rden at N+1, ram_addr=0x8005, fd_ack N+2, fd_valid with fd_rdata=0x1234 at N+3.
REQ-045 vw_req, fd_req, host_req all rise same cycle -> write first; with macro, detection then host; without macro, detection then host, then repeated both -> detection served each time.
REQ-046 frame_end pulse then fd_req addr 0x0005 -> ram_addr=0x0005 (wr_bank=1); host_req 0x8003 -> ram_addr 0x8003.
REQ-047 host_req held -> host_waitx=0 from first cycle until host_valid cycle, then 1.
REQ-048 reset asserted in READ -> next cycle IDLE, no fd_ack/fd_valid, host_waitx=1, wr_bank=0.

Source files
------------

// File: rtl/frame_ram_arbiter.sv
// rtl/frame_ram_arbiter.sv - single-port frame RAM arbiter: video write, detection read, host read
// Build option: FRAME_RAM_RR_FAIRNESS_EN selects round-robin between the two readers;
// without it the detection reader always wins a tie with the host.
module frame_ram_arbiter #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
) (
   input  logic              Sys_clk,
   input  logic              reset,
   input  logic              frame_end,
   input  logic              vw_req,
   input  logic [ADDR_W-2:0] vw_addr,
   input  logic [DATA_W-1:0] vw_data,
   output logic              vw_ack,
   input  logic              fd_req,
   input  logic [ADDR_W-2:0] fd_addr,
   output logic              fd_ack,
   output logic [DATA_W-1:0] fd_rdata,
   output logic              fd_valid,
   input  logic              host_req,
   input  logic [ADDR_W-1:0] host_addr,
   output logic              host_ack,
   output logic [DATA_W-1:0] host_rdata,
   output logic              host_valid,
   output logic              host_waitx,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   output logic              ram_wren,
   output logic              ram_rden,
   input  logic [DATA_W-1:0] ram_q,
   output logic              wr_bank
);

   typedef enum logic [1:0] {IDLE, WRITE, READ, RDATA} state_t;

   state_t state;
   state_t state_nxt;
   logic   grant_wr;
   logic   grant_rd;
   logic   pick_host;
   logic   rd_is_host;
   logic   host_done;

`ifdef FRAME_RAM_RR_FAIRNESS_EN
   logic rr_host;

   // Reader choice: on a tie the reader whose turn it is wins
   always_comb begin
      pick_host = host_req & (~fd_req | rr_host);
   end

   // Turn passes to the other reader after every read grant
   always_ff @(posedge Sys_clk) begin
      if (reset) begin
         rr_host <= 1'b0;
      end else if (grant_rd) begin
         rr_host <= ~pick_host;
      end
   end
`else
   // Reader choice: detection always beats host
   always_comb begin
      pick_host = host_req & ~fd_req;
   end
`endif

   // State register; reset abandons any access in flight
   always_ff @(posedge Sys_clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state, grants and per-state strobes; writer outranks both readers
   always_comb begin
      state_nxt = state;
      grant_wr  = 1'b0;
      grant_rd  = 1'b0;
      ram_wren  = 1'b0;
      ram_rden  = 1'b0;
      vw_ack    = 1'b0;
      fd_ack    = 1'b0;
      host_ack  = 1'b0;
      case (state)
         IDLE: begin
            if (vw_req) begin
               grant_wr  = 1'b1;
               state_nxt = WRITE;
            end else if (fd_req | host_req) begin
               grant_rd  = 1'b1;
               state_nxt = READ;
            end
         end
         WRITE: begin
            ram_wren  = 1'b1;
            vw_ack    = 1'b1;
            state_nxt = IDLE;
         end
         READ: begin
            ram_rden  = 1'b1;
            state_nxt = RDATA;
         end
         RDATA: begin
            fd_ack    = ~rd_is_host;
            host_ack  = rd_is_host;
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Capture address/data at grant so later requester changes cannot disturb the access;
   // detection reads always target the bank video is not writing
   always_ff @(posedge Sys_clk) begin
      if (!reset) begin
         if (grant_wr) begin
            ram_addr  <= {wr_bank, vw_addr};
            ram_wdata <= vw_data;
         end else if (grant_rd) begin
            ram_addr   <= pick_host ? host_addr : {~wr_bank, fd_addr};
            rd_is_host <= pick_host;
         end
      end
   end

   // Bank swap at frame end; a same-cycle write grant already sampled the old bank
   always_ff @(posedge Sys_clk) begin
      if (reset) begin
         wr_bank <= 1'b0;
      end else if (frame_end) begin
         wr_bank <= ~wr_bank;
      end
   end

   // Read return: RAM data is captured at the end of RDATA and held until the next read
   always_ff @(posedge Sys_clk) begin
      if (reset) begin
         fd_valid   <= 1'b0;
         host_valid <= 1'b0;
         fd_rdata   <= '0;
         host_rdata <= '0;
      end else begin
         fd_valid   <= (state == RDATA) & ~rd_is_host;
         host_valid <= (state == RDATA) & rd_is_host;
         if ((state == RDATA) && !rd_is_host) begin
            fd_rdata <= ram_q;
         end
         if ((state == RDATA) && rd_is_host) begin
            host_rdata <= ram_q;
         end
      end
   end

   // Remembers that the current host request has been answered, until host drops req
   always_ff @(posedge Sys_clk) begin
      if (reset) begin
         host_done <= 1'b0;
      end else if (!host_req) begin
         host_done <= 1'b0;
      end else if ((state == RDATA) && rd_is_host) begin
         host_done <= 1'b1;
      end
   end

   assign host_waitx = ~(host_req & ~host_done);

endmodule
